// File: rtl/tick_pkg.sv
// Shared definitions for the tick controller: controller states and default sizing.
package tick_pkg;

    localparam int unsigned DIV_W       = 17;
    localparam int unsigned DEFAULT_DIV = 100000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } tick_state_e;

endpackage

// File: rtl/prescale_counter.sv
// Free-running prescale counter that wraps at load_i-1 and flags the terminal count.
module prescale_counter import tick_pkg::*; #(
    parameter int unsigned WIDTH = DIV_W
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // load_i is never zero, so load_i-1 never underflows.
    assign tc_o = en_i && (count_q == (load_i - WIDTH'(1)));

    // Next count: clear dominates, otherwise count up and wrap on terminal count.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tick_controller.sv
// Clock-enable scheduler: registered tick, 50% div_clock and slow_tick from one clock,
// with a valid/ready port that retunes the divide ratio only on period boundaries.
module tick_controller #(
    parameter int unsigned WIDTH       = tick_pkg::DIV_W,
    parameter int unsigned DEFAULT_DIV = tick_pkg::DEFAULT_DIV,
    parameter int unsigned SLOW_DIV    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick,
    output logic             slow_tick,
    output logic             div_clock,
    output logic             busy
);

    import tick_pkg::*;

    localparam int unsigned          SLOW_W    = $clog2(SLOW_DIV);
    localparam logic [SLOW_W-1:0]    SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

    tick_state_e       state_q, state_d;
    logic [WIDTH-1:0]  div_q, div_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic [SLOW_W-1:0] slow_q, slow_d;
    logic              tick_q, tick_d;
    logic              slow_tick_q, slow_tick_d;
    logic              div_clock_q, div_clock_d;

    logic              run;
    logic              stop;
    logic              accept;
    logic              tc;
    logic [WIDTH-1:0]  cfg_clamped;

    assign run         = (state_q != IDLE);
    assign stop        = run && !enable;
    assign cfg_ready   = (state_q != PENDING);
    assign busy        = run;
    assign accept      = cfg_valid && cfg_ready;
    assign cfg_clamped = (cfg_div == '0) ? WIDTH'(1) : cfg_div;

    assign tick        = tick_q;
    assign slow_tick   = slow_tick_q;
    assign div_clock   = div_clock_q;

    // Counter is held at zero in IDLE and cleared on the stop edge, so entry always starts at 0.
    prescale_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clock_i  (clock),
        .reset_ni (reset),
        .clear_i  (!run || stop),
        .en_i     (run),
        .load_i   (div_q),
        .tc_o     (tc)
    );

    // Next-state, config handling and output decode.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        pend_d      = pend_q;
        slow_d      = slow_q;
        tick_d      = 1'b0;
        slow_tick_d = 1'b0;
        div_clock_d = div_clock_q;

        case (state_q)
            IDLE: begin
                slow_d      = '0;
                div_clock_d = 1'b0;
                if (accept) begin
                    div_d = cfg_clamped;
                end
                if (enable) begin
                    state_d = RUN;
                end
            end

            RUN, PENDING: begin
                if (stop) begin
                    // Stop beats terminal count; any waiting ratio lands directly.
                    state_d     = IDLE;
                    slow_d      = '0;
                    div_clock_d = 1'b0;
                    if (state_q == PENDING) begin
                        div_d = pend_q;
                    end else if (accept) begin
                        div_d = cfg_clamped;
                    end
                end else begin
                    if (tc) begin
                        tick_d      = 1'b1;
                        div_clock_d = ~div_clock_q;
                        if (slow_q == SLOW_LAST) begin
                            slow_d      = '0;
                            slow_tick_d = 1'b1;
                        end else begin
                            slow_d = slow_q + SLOW_W'(1);
                        end
                        if (state_q == PENDING) begin
                            div_d   = pend_q;
                            state_d = RUN;
                        end
                    end
                    // Only reachable from RUN since cfg_ready is low in PENDING.
                    if (accept) begin
                        pend_d  = cfg_clamped;
                        state_d = PENDING;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_q       <= WIDTH'(DEFAULT_DIV);
            pend_q      <= '0;
            slow_q      <= '0;
            tick_q      <= 1'b0;
            slow_tick_q <= 1'b0;
            div_clock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            slow_q      <= slow_d;
            tick_q      <= tick_d;
            slow_tick_q <= slow_tick_d;
            div_clock_q <= div_clock_d;
        end
    end

endmodule
